// File: rtl/sprite_anim_pkg.sv
// Shared definitions for the sprite animation sequencer: direction codes,
// facing / state enums and a small direction-decoding helper.
package sprite_anim_pkg;

    // Requested-motion codes on the dir input; any code with bit 2 set stops.
    localparam logic [2:0] DIR_LEFT  = 3'b000;
    localparam logic [2:0] DIR_RIGHT = 3'b001;
    localparam logic [2:0] DIR_DOWN  = 3'b010;
    localparam logic [2:0] DIR_UP    = 3'b011;
    localparam logic [2:0] DIR_STOP  = 3'b111;

    typedef enum logic [1:0] {
        FACE_LEFT  = 2'd0,
        FACE_RIGHT = 2'd1,
        FACE_DOWN  = 2'd2,
        FACE_UP    = 2'd3
    } facing_t;

    typedef enum logic {
        IDLE = 1'b0,
        WALK = 1'b1
    } anim_state_t;

    // Codes 000..011 request motion; the facing value is then dir[1:0].
    function automatic logic dir_is_move(input logic [2:0] d);
        return (d[2] == 1'b0);
    endfunction

endpackage

// File: rtl/anim_tick_gen.sv
// Animation step timer: free-running modulo-TICK_DIV counter that emits a
// registered one-cycle pulse in the cycle after the counter held TICK_DIV-1.
// Shared by the player and guard controllers.
module anim_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic vga_clk,
    input  logic Reset,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;
    logic             tick_q;

    // Next count: wrap to zero after TICK_DIV-1.
    always_comb begin
        wrap  = (cnt_q == CNT_W'(TICK_DIV - 1));
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    // Counter and pulse registers; reset restarts the full period.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/sprite_anim_seq.sv
// Sprite animation sequencer: IDLE/WALK state machine that tracks facing and
// walk-cycle frame on each animation step, plus a one-cycle-latency
// sprite-sheet address generator for the pixel currently being drawn.
module sprite_anim_seq
    import sprite_anim_pkg::*;
#(
    parameter int unsigned SPR_W    = 21,
    parameter int unsigned SPR_H    = 21,
    parameter int unsigned FRAMES   = 4,
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned ADDR_W   = $clog2(FRAMES * SPR_W * SPR_H)
) (
    input  logic                      vga_clk,
    input  logic                      Reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [9:0]                PosX,
    input  logic [9:0]                PosY,
    input  logic [2:0]                dir,
    output logic [1:0]                facing,
    output logic [$clog2(FRAMES)-1:0] frame,
    output logic                      walking,
    output logic                      anim_tick,
    output logic [ADDR_W-1:0]         rom_addr,
    output logic                      pix_active
);

    localparam int unsigned FRM_W = $clog2(FRAMES);
    localparam int unsigned PIX   = SPR_W * SPR_H;

    anim_state_t       state_q, state_d;
    facing_t           facing_q, facing_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic              tick;

    logic [10:0]       x_end, y_end;
    logic [10:0]       dx, dy;
    logic              in_box;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              pix_active_q;

    function automatic logic [FRM_W-1:0] frame_inc(input logic [FRM_W-1:0] f);
        return (f == FRM_W'(FRAMES - 1)) ? '0 : f + 1'b1;
    endfunction

    anim_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .vga_clk (vga_clk),
        .Reset   (Reset),
        .tick    (tick)
    );

    // FSM state register: state, facing and frame move only on a step.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            facing_q <= FACE_DOWN;
            frame_q  <= '0;
        end else begin
            state_q  <= state_d;
            facing_q <= facing_d;
            frame_q  <= frame_d;
        end
    end

    // FSM next state: decide walk/turn/stop from dir when a step arrives.
    always_comb begin
        state_d  = state_q;
        facing_d = facing_q;
        frame_d  = frame_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (dir_is_move(dir)) begin
                        state_d  = WALK;
                        facing_d = facing_t'(dir[1:0]);
                        frame_d  = '0;
                    end
                end
                WALK: begin
                    if (!dir_is_move(dir)) begin
                        // Stop keeps facing so the idle pose looks the way we walked.
                        state_d = IDLE;
                        frame_d = '0;
                    end else if (dir[1:0] == facing_q) begin
                        frame_d = frame_inc(frame_q);
                    end else begin
                        facing_d = facing_t'(dir[1:0]);
                        frame_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        walking   = (state_q == WALK);
        facing    = facing_q;
        frame     = frame_q;
        anim_tick = tick;
    end

    // Bounding-box test and sheet address, widened to 11 bits so boxes near
    // the right/bottom edge of the 10-bit coordinate space do not wrap.
    always_comb begin
        x_end  = {1'b0, PosX} + 11'(SPR_W);
        y_end  = {1'b0, PosY} + 11'(SPR_H);
        dx     = {1'b0, DrawX} - {1'b0, PosX};
        dy     = {1'b0, DrawY} - {1'b0, PosY};
        in_box = ({1'b0, DrawX} >= {1'b0, PosX}) && ({1'b0, DrawX} < x_end) &&
                 ({1'b0, DrawY} >= {1'b0, PosY}) && ({1'b0, DrawY} < y_end);
        // Uses the live frame, so a step landing mid-line changes the image there.
        addr_d = ADDR_W'(frame_q) * ADDR_W'(PIX) +
                 ADDR_W'(dy) * ADDR_W'(SPR_W) + ADDR_W'(dx);
    end

    // Address register: one cycle of latency to line up with a synchronous ROM.
    always_ff @(posedge vga_clk or posedge Reset) begin
        if (Reset) begin
            rom_addr_q   <= '0;
            pix_active_q <= 1'b0;
        end else begin
            rom_addr_q   <= in_box ? addr_d : '0;
            pix_active_q <= in_box;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pix_active = pix_active_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Directed bench for sprite_anim_seq with a short step period (TICK_DIV=4).
module tb_sprite_anim_seq;
    import sprite_anim_pkg::*;

    localparam int unsigned SPR_W    = 21;
    localparam int unsigned SPR_H    = 21;
    localparam int unsigned FRAMES   = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned ADDR_W   = $clog2(FRAMES * SPR_W * SPR_H);

    logic              vga_clk = 1'b0;
    logic              Reset;
    logic [9:0]        DrawX, DrawY, PosX, PosY;
    logic [2:0]        dir;
    logic [1:0]        facing;
    logic [1:0]        frame;
    logic              walking;
    logic              anim_tick;
    logic [ADDR_W-1:0] rom_addr;
    logic              pix_active;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [9:0] px, py, dx, dy;
        int         exp_addr;
        int         exp_act;
    } vec_t;

    vec_t tbl[10];

    sprite_anim_seq #(
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .FRAMES   (FRAMES),
        .TICK_DIV (TICK_DIV),
        .ADDR_W   (ADDR_W)
    ) dut (
        .vga_clk    (vga_clk),
        .Reset      (Reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .PosX       (PosX),
        .PosY       (PosY),
        .dir        (dir),
        .facing     (facing),
        .frame      (frame),
        .walking    (walking),
        .anim_tick  (anim_tick),
        .rom_addr   (rom_addr),
        .pix_active (pix_active)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running required finished");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for the anim_tick pulse, then one more cycle so the
    // state update that follows the pulse is visible.
    task automatic next_step(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge vga_clk);
            if (anim_tick) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_tick_seen"}, int'(got), 1);
        @(negedge vga_clk);
    endtask

    task automatic set_pix(input logic [9:0] px, input logic [9:0] py,
                           input logic [9:0] dx, input logic [9:0] dy);
        PosX = px; PosY = py; DrawX = dx; DrawY = dy;
    endtask

    initial begin
        // frame 0 (IDLE) address vectors: addr = dy*21 + dx
        tbl[0] = '{"inbox_a",   10'd100,  10'd50,   10'd105,  10'd52,   47,  1};
        tbl[1] = '{"right_out", 10'd100,  10'd50,   10'd121,  10'd52,   0,   0};
        tbl[2] = '{"corner_br", 10'd100,  10'd50,   10'd120,  10'd70,   440, 1};
        tbl[3] = '{"left_out",  10'd100,  10'd50,   10'd99,   10'd52,   0,   0};
        tbl[4] = '{"below_out", 10'd100,  10'd50,   10'd100,  10'd71,   0,   0};
        tbl[5] = '{"edge_x1020",10'd1015, 10'd1000, 10'd1020, 10'd1000, 5,   1};
        tbl[6] = '{"edge_x1023",10'd1015, 10'd1000, 10'd1023, 10'd1020, 428, 1};
        tbl[7] = '{"edge_left", 10'd1015, 10'd1000, 10'd1014, 10'd1000, 0,   0};
        tbl[8] = '{"origin",    10'd0,    10'd0,    10'd0,    10'd0,    0,   1};
        tbl[9] = '{"above_out", 10'd1015, 10'd1010, 10'd1020, 10'd1009, 0,   0};

        Reset = 1'b1;
        dir   = DIR_STOP;
        set_pix(10'd0, 10'd0, 10'd0, 10'd0);
        repeat (3) @(negedge vga_clk);

        // Reset state (draw position is in-box, outputs must still be clear)
        chk("rst_facing",   int'(facing),     2);
        chk("rst_frame",    int'(frame),      0);
        chk("rst_walking",  int'(walking),    0);
        chk("rst_tick",     int'(anim_tick),  0);
        chk("rst_addr",     int'(rom_addr),   0);
        chk("rst_active",   int'(pix_active), 0);

        // Walk right from reset
        dir   = DIR_RIGHT;
        Reset = 1'b0;
        begin
            int n = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge vga_clk);
                #1;
                n++;
                if (anim_tick) break;
            end
            chk("first_tick_latency", n, 4);
        end
        @(negedge vga_clk);
        chk("tick_high", int'(anim_tick), 1);
        @(negedge vga_clk);
        chk("tick_width",   int'(anim_tick), 0);
        chk("walk_start",   int'(walking),   1);
        chk("walk_facing",  int'(facing),    1);
        chk("walk_frame0",  int'(frame),     0);
        begin
            int exp_f[4] = '{1, 2, 3, 0};
            for (int k = 0; k < 4; k++) begin
                next_step("walk_seq");
                chk($sformatf("walk_frame_%0d", k), int'(frame), exp_f[k]);
                chk($sformatf("walk_facing_%0d", k), int'(facing), 1);
            end
        end

        // Turn to up at frame 2
        next_step("to_f1");
        next_step("to_f2");
        chk("pre_turn_frame", int'(frame), 2);
        dir = DIR_UP;
        next_step("turn_up");
        chk("turn_facing",  int'(facing),  3);
        chk("turn_frame",   int'(frame),   0);
        chk("turn_walking", int'(walking), 1);

        // Turn left, then stop: facing retained, outputs hold between steps
        dir = DIR_LEFT;
        next_step("turn_left");
        chk("left_facing", int'(facing), 0);
        chk("left_frame",  int'(frame),  0);
        dir = DIR_STOP;
        for (int k = 0; k < 2; k++) begin
            @(negedge vga_clk);
            chk($sformatf("hold_walking_%0d", k), int'(walking), 1);
            chk($sformatf("hold_facing_%0d", k),  int'(facing),  0);
        end
        next_step("stop");
        chk("stop_walking", int'(walking), 0);
        chk("stop_frame",   int'(frame),   0);
        chk("stop_facing",  int'(facing),  0);

        // Address table, IDLE so frame stays 0
        for (int i = 0; i < 10; i++) begin
            set_pix(tbl[i].px, tbl[i].py, tbl[i].dx, tbl[i].dy);
            @(negedge vga_clk);
            chk({tbl[i].name, "_addr"},   int'(rom_addr),   tbl[i].exp_addr);
            chk({tbl[i].name, "_active"}, int'(pix_active), tbl[i].exp_act);
        end

        // Address with frame 1
        dir = DIR_RIGHT;
        next_step("f1_start");
        next_step("f1_adv");
        chk("f1_frame", int'(frame), 1);
        set_pix(10'd100, 10'd50, 10'd105, 10'd52);
        @(negedge vga_clk);
        chk("f1_addr",   int'(rom_addr),   488);
        chk("f1_active", int'(pix_active), 1);
        DrawX = 10'd121;
        @(negedge vga_clk);
        chk("f1_out_addr",   int'(rom_addr),   0);
        chk("f1_out_active", int'(pix_active), 0);

        // Reset mid-walk at frame 3
        next_step("to_f2b");
        next_step("to_f3");
        chk("pre_rst_frame", int'(frame), 3);
        DrawX = 10'd105;
        @(negedge vga_clk);
        chk("f3_addr", int'(rom_addr), 1370);
        Reset = 1'b1;
        #1;
        chk("midrst_walking", int'(walking),    0);
        chk("midrst_frame",   int'(frame),      0);
        chk("midrst_facing",  int'(facing),     2);
        chk("midrst_addr",    int'(rom_addr),   0);
        chk("midrst_active",  int'(pix_active), 0);
        @(negedge vga_clk);
        Reset = 1'b0;
        begin
            int n = 0;
            for (int i = 0; i < 12; i++) begin
                @(posedge vga_clk);
                #1;
                n++;
                if (anim_tick) break;
            end
            chk("post_rst_tick_latency", n, 4);
        end
        @(negedge vga_clk);
        @(negedge vga_clk);
        chk("post_rst_walking", int'(walking), 1);
        chk("post_rst_facing",  int'(facing),  1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_anim_seq.md
SPRITE_ANIM_SEQ -- requirements
Module: sprite_anim_seq

Interface
REQ-001 Parameters SHALL be:
- SPR_W, default 21, sprite width in pixels.
- SPR_H, default 21, sprite height in pixels.
- FRAMES, default 4, animation frames per direction; minimum 2.
- TICK_DIV, default 100000, vga_clk cycles per animation step; minimum 2.
- ADDR_W, default $clog2(FRAMES*SPR_W*SPR_H), ROM address width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- vga_clk, in, 1, the one clock.
- Reset, in, 1, asynchronous active-high reset.
- DrawX, in, 10, current pixel column.
- DrawY, in, 10, current pixel row.
- PosX, in, 10, sprite top-left column.
- PosY, in, 10, sprite top-left row.
- dir, in, 3, requested motion: 000 left, 001 right, 010 down, 011 up; any other code means stop.
- facing, out, 2, current facing: 0 left, 1 right, 2 down, 3 up.
- frame, out, $clog2(FRAMES), current animation frame.
- walking, out, 1, high while in state WALK.
- anim_tick, out, 1, one-cycle step pulse.
- rom_addr, out, ADDR_W, sprite-sheet address for (DrawX, DrawY), registered.
- pix_active, out, 1, high when rom_addr refers to an in-box pixel, registered.

REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; the clock port is vga_clk and the reset port is Reset.

Function
REQ-004 A tick counter SHALL count 0 to TICK_DIV-1 and then wrap to 0; anim_tick SHALL be high for exactly the cycle after the counter holds TICK_DIV-1.
REQ-005 State (IDLE/WALK), facing and frame SHALL change only on cycles where the counter wraps, and SHALL hold otherwise.
REQ-006 IDLE, valid dir on wrap: go to WALK, set facing=dir[1:0], set frame=0.
REQ-007 IDLE, stop code on wrap: stay IDLE; facing and frame unchanged.
REQ-008 WALK, dir equal to facing on wrap: frame increments, wrapping from FRAMES-1 to 0.
REQ-009 WALK, valid dir different from facing on wrap: stay WALK, set facing=dir[1:0], set frame=0.
REQ-010 WALK, stop code on wrap: go to IDLE, set frame=0, retain facing. The stationary pose SHALL face the last direction walked, not always down.
REQ-011 walking SHALL equal (state==WALK).
REQ-012 The in-box test SHALL be PosX<=DrawX<PosX+SPR_W and PosY<=DrawY<PosY+SPR_H, evaluated at 11-bit width so that PosX+SPR_W>1023 does not wrap.
REQ-013 In-box, the registered rom_addr SHALL equal frame*SPR_W*SPR_H + (DrawY-PosY)*SPR_W + (DrawX-PosX), computed at ADDR_W width without truncation.
REQ-014 Out-of-box, the registered rom_addr SHALL be 0 and pix_active SHALL be 0.
REQ-015 rom_addr and pix_active SHALL have exactly one cycle of latency from DrawX/DrawY, so pix_active aligns with a synchronous ROM's 1-cycle q output.
REQ-016 The address computation SHALL use the frame value of the current cycle. A frame change may land mid-scanline; this is accepted and SHALL NOT be suppressed.

Reset
REQ-017 While Reset is high, all of the following SHALL hold, asynchronously:
- tick counter=0
- state=IDLE
- facing=2 (down)
- frame=0
- walking=0
- anim_tick=0
- rom_addr=0
- pix_active=0
REQ-018 Reset asserted mid-walk SHALL abandon the current frame immediately. After Reset deasserts, the first step SHALL occur TICK_DIV cycles later.

Structure
REQ-019 Package sprite_anim_pkg SHALL hold the dir code constants (DIR_LEFT/RIGHT/DOWN/UP/STOP), the facing_t enum and the anim_state_t enum (IDLE, WALK).
REQ-020 Sub-module anim_tick_gen (parameter TICK_DIV; ports vga_clk, Reset, tick) SHALL implement REQ-004. It SHALL be reusable by the guard and player controllers.

Verification
REQ-021 The bench SHALL use TICK_DIV=4, FRAMES=4, SPR_W=SPR_H=21, and SHALL cover:
- Reset, then dir=001 held: walking goes high at the first tick, and frame runs 0,1,2,3,0 on consecutive ticks with facing=1.
- WALK with facing=1 at frame=2, dir changed to 011: the next tick gives facing=3, frame=0, walking=1.
- WALK with facing=0, dir=111: the next tick gives walking=0, frame=0, facing=0 (retained). Between ticks, outputs do not change.
- PosX=100, PosY=50, frame=1, DrawX=105, DrawY=52: one cycle later rom_addr=441+42+5=488 and pix_active=1. DrawX=121: one cycle later pix_active=0 and rom_addr=0.
- PosX=1015, DrawX=1020, DrawY=PosY: pix_active=1 (no wrap). DrawX=1023 with PosX=1015: pix_active=1.
- Reset pulsed for one cycle mid-walk at frame=3: immediately state=IDLE, frame=0, facing=2. The next anim_tick occurs 4 cycles after Reset deasserts.
